// File: rtl/rotate_coord_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rotate_pkg
// Brief   : Shared types, constants and coefficient helper for the rotate path
// Revision: 1.0
// ============================================================================
package rotate_pkg;

    typedef logic signed [11:0] coord_t;
    typedef logic signed [9:0]  coef_t;
    typedef logic signed [21:0] prod_t;
    typedef logic signed [22:0] sum_t;

    localparam int ANG_MAX     = 360;
    localparam int Q_SHIFT     = 8;
    localparam int ANG_COS_OFS = 90;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_SIN  = 3'd1,
        S_COS  = 3'd2,
        S_WAIT = 3'd3,
        S_SCAN = 3'd4,
        DONE   = 3'd5
    } rot_state_e;

    // Table full-scale (+-255) is stretched to +-256 so quadrant angles are exact.
    function automatic coef_t promote_coef(input logic signed [8:0] d);
        if (d == 9'sd255)
            return 10'sd256;
        else if (d == -9'sd255)
            return -10'sd256;
        else
            return coef_t'(d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rotate_coord_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : rotate_coord_gen_if
// Brief   : Source-coordinate stream towards the pixel fetcher
// Revision: 1.0
// ============================================================================
interface rotate_coord_gen_if;
    import rotate_pkg::*;

    logic   out_valid;
    logic   out_ready;
    coord_t src_x;
    coord_t src_y;
    logic   in_img;

    modport master (output out_valid, src_x, src_y, in_img, input out_ready);
    modport slave  (input out_valid, src_x, src_y, in_img, output out_ready);

endinterface
`default_nettype wire

// File: rtl/rotate_coord_gen_mac.sv
`default_nettype none
// ============================================================================
// Module  : rotate_mac
// Brief   : One-axis rotate MAC: stage 1 multiplies, stage 2 sums/shifts/offsets
// Revision: 1.0
// ============================================================================
module rotate_mac
    import rotate_pkg::*;
#(
    parameter bit SUB = 1'b0,
    parameter int OFS = 0,
    parameter int LIM = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   i_en1,
    input  wire logic   i_en2,
    input  wire coord_t i_a,
    input  wire coef_t  i_ca,
    input  wire coord_t i_b,
    input  wire coef_t  i_cb,
    output coord_t      o_res,
    output logic        o_in_range
);

    prod_t r_pa;
    prod_t r_pb;
    sum_t  w_pa;
    sum_t  w_pb;
    sum_t  w_sum;
    sum_t  w_shift;
    sum_t  w_full;
    logic  w_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pa <= '0;
            r_pb <= '0;
        end else if (i_en1) begin
            r_pa <= prod_t'(i_a) * prod_t'(i_ca);
            r_pb <= prod_t'(i_b) * prod_t'(i_cb);
        end
    end

    assign w_pa    = sum_t'(r_pa);
    assign w_pb    = sum_t'(r_pb);
    assign w_sum   = SUB ? (w_pa - w_pb) : (w_pa + w_pb);
    assign w_shift = w_sum >>> Q_SHIFT;
    assign w_full  = w_shift + sum_t'(OFS);
    // Range test uses the untruncated value so far-out coordinates cannot alias back in.
    assign w_in_range = !w_full[22] && (w_full < sum_t'(LIM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_res      <= '0;
            o_in_range <= 1'b0;
        end else if (i_en2) begin
            o_res      <= w_full[11:0];
            o_in_range <= w_in_range;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rotate_coord_gen.sv
`default_nettype none
// ============================================================================
// Module  : rotate_coord_gen
// Brief   : Fetches sin/cos once per frame, then raster-scans and emits source coords
// Revision: 1.0
// ============================================================================
module rotate_coord_gen
    import rotate_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CX    = 320,
    parameter int CY    = 240
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          start,
    input  wire logic [8:0]    angle,
    output logic               sin_rd_en,
    output logic [8:0]         sin_addr,
    input  wire logic [8:0]    sin_dout,
    rotate_coord_gen_if.master pix,
    output logic               busy,
    output logic               done
);

    rot_state_e r_state;
    logic [8:0] r_ang;
    coef_t      r_sin;
    coef_t      r_cos;
    coord_t     r_x;
    coord_t     r_y;
    logic       r_issued_all;
    logic       r_v1;
    logic       r_last1;
    logic       r_v2;
    logic       r_last2;

    logic [8:0] w_ang_red;
    logic [9:0] w_cos_sum;
    logic [8:0] w_cos_addr;
    logic       w_adv;
    logic       w_issue;
    logic       w_last_px;
    logic       w_final_hs;
    coord_t     w_dx;
    coord_t     w_dy;
    logic       w_inr_x;
    logic       w_inr_y;

    assign w_ang_red  = (angle >= 9'(ANG_MAX)) ? 9'(angle - 9'(ANG_MAX)) : angle;
    assign w_cos_sum  = {1'b0, r_ang} + 10'(ANG_COS_OFS);
    assign w_cos_addr = (w_cos_sum >= 10'(ANG_MAX)) ? 9'(w_cos_sum - 10'(ANG_MAX))
                                                    : w_cos_sum[8:0];

    // Everything moves together unless a valid output is being held back.
    assign w_adv      = !(r_v2 && !pix.out_ready);
    assign w_issue    = (r_state == S_SCAN) && !r_issued_all && w_adv;
    assign w_last_px  = (r_x == coord_t'(IMG_W - 1)) && (r_y == coord_t'(IMG_H - 1));
    assign w_final_hs = r_v2 && r_last2 && pix.out_ready;
    assign w_dx       = r_x - coord_t'(CX);
    assign w_dy       = r_y - coord_t'(CY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ang        <= '0;
            r_sin        <= '0;
            r_cos        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_issued_all <= 1'b0;
            sin_rd_en    <= 1'b0;
            sin_addr     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ang        <= w_ang_red;
                        sin_addr     <= w_ang_red;
                        sin_rd_en    <= 1'b1;
                        busy         <= 1'b1;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_issued_all <= 1'b0;
                        r_state      <= S_SIN;
                    end
                end
                S_SIN: begin
                    sin_addr <= w_cos_addr;
                    r_state  <= S_COS;
                end
                // Table data trails its address by one cycle: sin is on sin_dout here.
                S_COS: begin
                    sin_rd_en <= 1'b0;
                    r_sin     <= promote_coef(sin_dout);
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    r_cos   <= promote_coef(sin_dout);
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    if (w_issue) begin
                        if (w_last_px) begin
                            r_issued_all <= 1'b1;
                        end else if (r_x == coord_t'(IMG_W - 1)) begin
                            r_x <= '0;
                            r_y <= r_y + 12'sd1;
                        end else begin
                            r_x <= r_x + 12'sd1;
                        end
                    end
                    if (w_final_hs) begin
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
        end else if (w_adv) begin
            r_v1    <= w_issue;
            r_last1 <= w_issue && w_last_px;
            r_v2    <= r_v1;
            r_last2 <= r_last1;
        end
    end

    rotate_mac #(
        .SUB (1'b0),
        .OFS (CX),
        .LIM (IMG_W)
    ) u_mac_x (
        .clk        (clk),
        .rst        (rst),
        .i_en1      (w_issue),
        .i_en2      (w_adv && r_v1),
        .i_a        (w_dx),
        .i_ca       (r_cos),
        .i_b        (w_dy),
        .i_cb       (r_sin),
        .o_res      (pix.src_x),
        .o_in_range (w_inr_x)
    );

    rotate_mac #(
        .SUB (1'b1),
        .OFS (CY),
        .LIM (IMG_H)
    ) u_mac_y (
        .clk        (clk),
        .rst        (rst),
        .i_en1      (w_issue),
        .i_en2      (w_adv && r_v1),
        .i_a        (w_dy),
        .i_ca       (r_cos),
        .i_b        (w_dx),
        .i_cb       (r_sin),
        .o_res      (pix.src_y),
        .o_in_range (w_inr_y)
    );

    assign pix.out_valid = r_v2;
    assign pix.in_img    = w_inr_x && w_inr_y;

endmodule
`default_nettype wire

// File: tb/tb_rotate_coord_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_rotate_coord_gen
// Brief   : Directed bench for rotate_coord_gen on a reduced 16x12 frame
// Revision: 1.0
// ============================================================================
module tb_rotate_coord_gen;
    import rotate_pkg::*;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int X0 = 8;
    localparam int Y0 = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [8:0] angle;
    logic       sin_rd_en;
    logic [8:0] sin_addr;
    logic [8:0] sin_dout;
    logic       busy;
    logic       done;

    int total;
    int bad;

    logic [11:0] cap_x  [W*H];
    logic [11:0] cap_y  [W*H];
    logic        cap_in [W*H];

    rotate_coord_gen_if pix ();

    rotate_coord_gen #(
        .IMG_W (W),
        .IMG_H (H),
        .CX    (X0),
        .CY    (Y0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .angle     (angle),
        .sin_rd_en (sin_rd_en),
        .sin_addr  (sin_addr),
        .sin_dout  (sin_dout),
        .pix       (pix),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // sin table, Q8, rounded: sin40=0.643 -> 164, sin130=0.766 -> 195
    function automatic logic [8:0] tbl(input logic [8:0] a);
        case (a)
            9'd90:   tbl = 9'd255;
            9'd270:  tbl = 9'h101;
            9'd40:   tbl = 9'd164;
            9'd130:  tbl = 9'd195;
            default: tbl = 9'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst)
            sin_dout <= '0;
        else if (sin_rd_en)
            sin_dout <= tbl(sin_addr);
    end

    function automatic void exp_px(input int kind, input int x, input int y,
                                   output int ex, output int ey);
        case (kind)
            0:       begin ex = x;               ey = y;               end
            1:       begin ex = y - Y0 + X0;     ey = X0 - x + Y0;     end
            2:       begin ex = 2*X0 - x;        ey = 2*Y0 - y;        end
            3:       begin ex = Y0 - y + X0;     ey = x - X0 + Y0;     end
            default: begin ex = 0;               ey = 0;               end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string t);
        chk({t, "_valid"}, {31'd0, pix.out_valid}, 0);
        chk({t, "_srcx"},  {20'd0, pix.src_x}, 0);
        chk({t, "_srcy"},  {20'd0, pix.src_y}, 0);
        chk({t, "_inimg"}, {31'd0, pix.in_img}, 0);
        chk({t, "_busy"},  {31'd0, busy}, 0);
        chk({t, "_done"},  {31'd0, done}, 0);
        chk({t, "_rden"},  {31'd0, sin_rd_en}, 0);
        chk({t, "_addr"},  {23'd0, sin_addr}, 0);
    endtask

    task automatic run_frame(input logic [8:0] ang, input logic [8:0] es, input logic [8:0] ec,
                             input int kind, input bit rnd, input bit hold, input int abort_at);
        int n, dn, cyc, ex, ey;
        bit pv;
        logic [11:0] px, py;
        logic pin;
        n = 0; dn = 0; cyc = 0; pv = 1'b0; px = '0; py = '0; pin = 1'b0;
        pix.out_ready = 1'b1;
        angle = ang;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        chk("busy_rise", {31'd0, busy}, 1);
        chk("rden_sin",  {31'd0, sin_rd_en}, 1);
        chk("addr_sin",  {23'd0, sin_addr}, {23'd0, es});
        @(posedge clk); #1;
        chk("rden_cos",  {31'd0, sin_rd_en}, 1);
        chk("addr_cos",  {23'd0, sin_addr}, {23'd0, ec});
        @(posedge clk); #1;
        chk("rden_off",  {31'd0, sin_rd_en}, 0);
        chk("addr_hold", {23'd0, sin_addr}, {23'd0, ec});
        @(posedge clk); #1;
        chk("valid_e3",  {31'd0, pix.out_valid}, 0);
        @(posedge clk); #1;
        chk("valid_e4",  {31'd0, pix.out_valid}, 0);
        @(posedge clk); #1;
        chk("valid_e5",  {31'd0, pix.out_valid}, 1);
        while (dn == 0 && cyc < 4000) begin
            pix.out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            @(negedge clk);
            if (pv) begin
                chk("stall_valid", {31'd0, pix.out_valid}, 1);
                chk("stall_x",     {20'd0, pix.src_x}, {20'd0, px});
                chk("stall_y",     {20'd0, pix.src_y}, {20'd0, py});
                chk("stall_in",    {31'd0, pix.in_img}, {31'd0, pin});
            end
            pv  = pix.out_valid && !pix.out_ready;
            px  = pix.src_x;
            py  = pix.src_y;
            pin = pix.in_img;
            if (pix.out_valid && pix.out_ready) begin
                if (n < W*H) begin
                    cap_x[n]  = pix.src_x;
                    cap_y[n]  = pix.src_y;
                    cap_in[n] = pix.in_img;
                    if (kind < 4) begin
                        exp_px(kind, n % W, n / W, ex, ey);
                        chk($sformatf("x@%0d", n), {20'd0, pix.src_x}, {20'd0, 12'(ex)});
                        chk($sformatf("y@%0d", n), {20'd0, pix.src_y}, {20'd0, 12'(ey)});
                        chk($sformatf("in@%0d", n), {31'd0, pix.in_img},
                            {31'd0, (ex >= 0 && ex < W && ey >= 0 && ey < H)});
                    end
                end
                n++;
                if (abort_at != 0 && n == abort_at) begin
                    rst = 1'b1;
                    #1;
                    chk_all_zero("abort");
                    @(posedge clk); #1;
                    rst = 1'b0;
                    return;
                end
            end
            if (done) dn++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", dn, 1);
        chk("hs_count", n, W*H);
        @(negedge clk);
        chk("done_once", {31'd0, done}, 0);
        chk("busy_fall", {31'd0, busy}, 0);
        chk("valid_idle", {31'd0, pix.out_valid}, 0);
        if (hold) begin
            @(negedge clk);
            chk("restart_busy", {31'd0, busy}, 1);
        end
    endtask

    initial begin
        int cyc;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        angle = '0;
        pix.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // identity mapping, ready always high
        run_frame(9'd0, 9'd0, 9'd90, 0, 1'b0, 1'b0, 0);
        chk("a0_x_10_6",  {20'd0, cap_x[6*W+10]}, 32'd10);
        chk("a0_y_10_6",  {20'd0, cap_y[6*W+10]}, 32'd6);
        chk("a0_in_10_6", {31'd0, cap_in[6*W+10]}, 32'd1);

        // 90 degrees with 30% ready
        run_frame(9'd90, 9'd90, 9'd180, 1, 1'b1, 1'b0, 0);
        chk("a90_x_10_6", {20'd0, cap_x[6*W+10]}, 32'd8);
        chk("a90_y_10_6", {20'd0, cap_y[6*W+10]}, 32'd4);
        chk("a90_x_0_0",  {20'd0, cap_x[0]}, 32'd2);
        chk("a90_y_0_0",  {20'd0, cap_y[0]}, 32'd14);
        chk("a90_in_0_0", {31'd0, cap_in[0]}, 32'd0);

        run_frame(9'd180, 9'd180, 9'd270, 2, 1'b0, 1'b0, 0);
        chk("a180_x_10_7", {20'd0, cap_x[7*W+10]}, 32'd6);
        chk("a180_y_10_7", {20'd0, cap_y[7*W+10]}, 32'd5);

        // 400 reduces to 40: S=164, C=195, floor shift on negatives
        run_frame(9'd400, 9'd40, 9'd130, 4, 1'b0, 1'b0, 0);
        chk("a40_x_10_7",  {20'd0, cap_x[7*W+10]}, 32'd10);
        chk("a40_y_10_7",  {20'd0, cap_y[7*W+10]}, 32'd5);
        chk("a40_in_10_7", {31'd0, cap_in[7*W+10]}, 32'd1);
        chk("a40_x_0_0",   {20'd0, cap_x[0]}, 32'h0000_0FFE);
        chk("a40_y_0_0",   {20'd0, cap_y[0]}, 32'd6);
        chk("a40_in_0_0",  {31'd0, cap_in[0]}, 32'd0);

        run_frame(9'd270, 9'd270, 9'd0, 3, 1'b1, 1'b0, 0);

        // reset mid-frame, then a clean frame from (0,0)
        run_frame(9'd0, 9'd0, 9'd90, 0, 1'b0, 1'b0, 100);
        run_frame(9'd0, 9'd0, 9'd90, 0, 1'b0, 1'b0, 0);

        // start held through the frame: ignored while busy, re-accepted after DONE
        run_frame(9'd180, 9'd180, 9'd270, 2, 1'b0, 1'b1, 0);
        start = 1'b0;
        pix.out_ready = 1'b1;
        cyc = 0;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("frame2_done", {31'd0, done}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
